alu_seq: RTL

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Operand width is configurable (WIDTH), the opcode is extended to 4 bits, and there are valid/ready handshakes on input and output.
- Adds signed-overflow and negative flags, a sticky carry for add-with-carry, and iterative multi-cycle shifts by a variable amount.
- Sits between the operand register file and the writeback stage; one operation is in flight at a time.

---
 rtl/alu_seq.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with valid/ready handshakes, flags and a sticky carry.
// Define ALU_SEQ_MUL_EN to enable the iterative shift-add multiplier on opcode 1101.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err,
    output logic             busy
);
    // Counter needs one extra bit so it can hold WIDTH for the multiplier.
    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL1 = 4'h6;
    localparam logic [3:0] OP_SHR1 = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBB  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_ASR  = 4'hC;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'hD;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic             carry_flag_q, carry_flag_d;
`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

    logic             cin;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [SHW-1:0]   amt;
    logic             fin, fin_carry, fin_ovf, fin_err, shift_out;
    logic [WIDTH-1:0] fin_res;

    // The sticky carry only feeds ADC/SBB; ADD/SUB see a zero carry-in.
    always_comb begin
        cin      = (op == OP_ADC || op == OP_SBB) ? carry_flag_q : 1'b0;
        sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        amt      = b[SHW-1:0];
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        result_d     = result_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        carry_flag_d = carry_flag_q;
        fin          = 1'b0;
        fin_res      = '0;
        fin_carry    = 1'b0;
        fin_ovf      = 1'b0;
        fin_err      = 1'b0;
        shift_out    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        prod_d       = prod_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    work_d = a;
                    case (op)
                        OP_ADD, OP_ADC: begin
                            fin       = 1'b1;
                            fin_res   = sum_ext[WIDTH-1:0];
                            fin_carry = sum_ext[WIDTH];
                            fin_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB, OP_SBB: begin
                            fin       = 1'b1;
                            fin_res   = diff_ext[WIDTH-1:0];
                            fin_carry = diff_ext[WIDTH];
                            fin_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND: begin fin = 1'b1; fin_res = a & b; end
                        OP_OR:  begin fin = 1'b1; fin_res = a | b; end
                        OP_XOR: begin fin = 1'b1; fin_res = a ^ b; end
                        OP_NOT: begin fin = 1'b1; fin_res = ~a; end
                        OP_SHL1: begin
                            fin       = 1'b1;
                            fin_res   = a << 1;
                            fin_carry = a[WIDTH-1];
                        end
                        OP_SHR1: begin
                            fin       = 1'b1;
                            fin_res   = a >> 1;
                            fin_carry = a[0];
                        end
                        OP_SHL, OP_SHR, OP_ASR: begin
                            cnt_d = {1'b0, amt};
                            if (amt == '0) begin
                                fin     = 1'b1;
                                fin_res = a;
                            end else begin
                                state_d = BUSY;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            prod_d   = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            mplier_d = b;
                            cnt_d    = CW'(WIDTH);
                            state_d  = BUSY;
                        end
`endif
                        default: begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                case (op_q)
                    OP_SHL: begin shift_out = work_q[WIDTH-1]; work_d = work_q << 1; end
                    OP_SHR: begin shift_out = work_q[0]; work_d = work_q >> 1; end
                    OP_ASR: begin shift_out = work_q[0]; work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; end
                    default: ;
                endcase
                fin_res   = work_d;
                fin_carry = shift_out;
`ifdef ALU_SEQ_MUL_EN
                if (op_q == OP_MUL) begin
                    prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d   = mcand_q << 1;
                    mplier_d  = mplier_q >> 1;
                    fin_res   = prod_d[WIDTH-1:0];
                    fin_carry = |prod_d[2*WIDTH-1:WIDTH];
                end
`endif
                if (cnt_q == CW'(1)) begin
                    fin = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags and the sticky carry are captured once, on entry to DONE.
        if (fin) begin
            state_d  = DONE;
            result_d = fin_res;
            carry_d  = fin_carry;
            zero_d   = (fin_res == '0);
            neg_d    = fin_res[WIDTH-1];
            ovf_d    = fin_ovf;
            err_d    = fin_err;
            if (!fin_err) begin
                carry_flag_d = fin_carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            work_q       <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            carry_flag_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q       <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            carry_flag_q <= carry_flag_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q       <= prod_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
`endif
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
endmodule
